// File: rtl/rect_fill_engine.sv
// Solid rectangle fill engine: clips a command to the visible area and emits
// one raster-order frame-buffer write per clock on port B.
module rect_fill_engine #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 4
) (
    input  logic              clk_100m,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_x,
    input  logic [9:0]        cmd_y,
    input  logic [9:0]        cmd_w,
    input  logic [9:0]        cmd_h,
    input  logic [DATA_W-1:0] cmd_color,
    output logic              busy,
    output logic              done,
    output logic              web,
    output logic [ADDR_W-1:0] addrb,
    output logic [DATA_W-1:0] dinb,
    output logic [1:0]        dbg_state
);

    // Handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both high; cmd_ready is high only in IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLIP = 2'd1,
        S_FILL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [10:0]       LP_H    = 11'(H_RES);
    localparam logic [10:0]       LP_V    = 11'(V_RES);
    localparam logic [ADDR_W-1:0] LP_STEP = ADDR_W'(H_RES);

    state_t              r_state;
    state_t              w_next;
    logic [9:0]          r_x, r_y, r_w, r_h;
    logic [DATA_W-1:0]   r_color;
    logic [10:0]         r_x_end, r_y_end;
    logic [9:0]          r_col, r_row;
    logic [ADDR_W-1:0]   r_row_base;

    logic [10:0]         w_x_sum, w_y_sum, w_x_end, w_y_end;
    logic [ADDR_W-1:0]   w_y_base;
    logic                w_empty, w_last_col, w_last_row;

    // 11-bit sums cannot overflow for 10-bit operands.
    assign w_x_sum  = {1'b0, r_x} + {1'b0, r_w};
    assign w_y_sum  = {1'b0, r_y} + {1'b0, r_h};
    assign w_x_end  = (w_x_sum > LP_H) ? LP_H : w_x_sum;
    assign w_y_end  = (w_y_sum > LP_V) ? LP_V : w_y_sum;
    assign w_y_base = (ADDR_W'(r_y) << 9) + (ADDR_W'(r_y) << 7);
    assign w_empty  = (r_w == 10'd0) || (r_h == 10'd0) ||
                      ({1'b0, r_x} >= LP_H) || ({1'b0, r_y} >= LP_V);

    assign w_last_col = ({1'b0, r_col} == (r_x_end - 11'd1));
    assign w_last_row = ({1'b0, r_row} == (r_y_end - 11'd1));

    always_ff @(posedge clk_100m) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_x        <= '0;
            r_y        <= '0;
            r_w        <= '0;
            r_h        <= '0;
            r_color    <= '0;
            r_x_end    <= '0;
            r_y_end    <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_x     <= cmd_x;
                        r_y     <= cmd_y;
                        r_w     <= cmd_w;
                        r_h     <= cmd_h;
                        r_color <= cmd_color;
                    end
                end
                S_CLIP: begin
                    r_x_end    <= w_x_end;
                    r_y_end    <= w_y_end;
                    r_row_base <= w_y_base;
                    r_col      <= r_x;
                    r_row      <= r_y;
                end
                S_FILL: begin
                    if (w_last_col) begin
                        r_col      <= r_x;
                        r_row      <= r_row + 10'd1;
                        r_row_base <= r_row_base + LP_STEP;
                    end else begin
                        r_col <= r_col + 10'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        web       = 1'b0;
        addrb     = '0;
        dinb      = '0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) w_next = S_CLIP;
            end
            S_CLIP: begin
                busy   = 1'b1;
                w_next = w_empty ? S_DONE : S_FILL;
            end
            S_FILL: begin
                busy  = 1'b1;
                web   = 1'b1;
                addrb = r_row_base + ADDR_W'(r_col);
                dinb  = r_color;
                if (w_last_col && w_last_row) w_next = S_DONE;
            end
            S_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign dbg_state = r_state;

endmodule
